// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: load/store handshake with a
// variable-latency data memory, branch redirect, stall and the MEM/WB register.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_regWrite_ex_mem,
  input  logic              ctrl_memToReg_ex_mem,
  input  logic              ctrl_branch_ex_mem,
  input  logic              ctrl_memRead_ex_mem,
  input  logic              ctrl_memWrite_ex_mem,
  input  logic              zero_ex_mem,
  input  logic [DATA_W-1:0] branch_or_not_address_ex_mem,
  input  logic [DATA_W-1:0] alu_result_ex_mem,
  input  logic [DATA_W-1:0] read_data_2_ex_mem,
  input  logic [REG_W-1:0]  write_register_ex_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_stall,
  output logic              ctrl_regWrite_mem_wb,
  output logic              ctrl_memToReg_mem_wb,
  output logic [DATA_W-1:0] read_data_mem_wb,
  output logic [DATA_W-1:0] alu_result_mem_wb,
  output logic [REG_W-1:0]  write_register_mem_wb,
  output logic              misaligned_err,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_err_q, bus_err_d;
  logic               mis_err_q, mis_err_d;
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [REG_W-1:0]   wreg_q, wreg_d;

  logic mem_op_s, mis_s, acc_s, timeout_now_s, complete_s, abort_s, load_s, bubble_s;

  assign mem_op_s      = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
  assign mis_s         = mem_op_s & (alu_result_ex_mem[1:0] != 2'b00);
  assign acc_s         = mem_op_s & ~mis_s;
  // A store wins when both read and write are flagged.
  assign load_s        = ctrl_memRead_ex_mem & ~ctrl_memWrite_ex_mem;
  assign timeout_now_s = (state_q == S_WAIT) & (cnt_q == CNT_LAST);

  // Request is killed combinationally while reset is held so a pending access aborts at once.
  assign dmem_req   = acc_s & ~reset;
  assign dmem_we    = ctrl_memWrite_ex_mem;
  assign dmem_addr  = alu_result_ex_mem;
  assign dmem_wdata = read_data_2_ex_mem;

  assign mem_stall  = dmem_req & ~dmem_ack & ~timeout_now_s;
  assign complete_s = dmem_req & dmem_ack;
  assign abort_s    = dmem_req & ~dmem_ack & timeout_now_s;
  assign bubble_s   = mis_s | mem_stall | abort_s;

  assign pc_src        = ctrl_branch_ex_mem & zero_ex_mem & ~mem_stall;
  assign branch_target = branch_or_not_address_ex_mem;

  assign ctrl_regWrite_mem_wb  = regwrite_q;
  assign ctrl_memToReg_mem_wb  = memtoreg_q;
  assign read_data_mem_wb      = rdata_q;
  assign alu_result_mem_wb     = alu_q;
  assign write_register_mem_wb = wreg_q;
  assign misaligned_err        = mis_err_q;
  assign bus_err               = bus_err_q;

  // Access FSM: wait counter and sticky bus error.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (!dmem_req || dmem_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (timeout_now_s) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MEM/WB next value: pass on completion or non-memory op, bubble otherwise.
  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    rdata_d    = rdata_q;
    alu_d      = alu_q;
    wreg_d     = wreg_q;
    mis_err_d  = mis_s;
    if (bubble_s) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else begin
      regwrite_d = ctrl_regWrite_ex_mem;
      memtoreg_d = ctrl_memToReg_ex_mem;
      alu_d      = alu_result_ex_mem;
      wreg_d     = write_register_ex_mem;
      if (complete_s && load_s) begin
        rdata_d = dmem_rdata;
      end else begin
        rdata_d = rdata_q;
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
      mis_err_q  <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rdata_q    <= '0;
      alu_q      <= '0;
      wreg_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      mis_err_q  <= mis_err_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      wreg_q     <= wreg_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the access rules.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rw_i, m2r_i, br_i, rd_i, wr_i, zero_i;
  logic [31:0] tgt_i, alu_i, wd_i;
  logic [4:0]  wreg_i;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        pc_src, mem_stall;
  logic [31:0] branch_target;
  logic        rw_o, m2r_o;
  logic [31:0] rd_o, alu_o;
  logic [4:0]  wreg_o;
  logic        misaligned_err, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ctrl_regWrite_ex_mem(rw_i), .ctrl_memToReg_ex_mem(m2r_i),
    .ctrl_branch_ex_mem(br_i), .ctrl_memRead_ex_mem(rd_i),
    .ctrl_memWrite_ex_mem(wr_i), .zero_ex_mem(zero_i),
    .branch_or_not_address_ex_mem(tgt_i), .alu_result_ex_mem(alu_i),
    .read_data_2_ex_mem(wd_i), .write_register_ex_mem(wreg_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_src(pc_src), .branch_target(branch_target), .mem_stall(mem_stall),
    .ctrl_regWrite_mem_wb(rw_o), .ctrl_memToReg_mem_wb(m2r_o),
    .read_data_mem_wb(rd_o), .alu_result_mem_wb(alu_o),
    .write_register_mem_wb(wreg_o), .misaligned_err(misaligned_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Behavioural model state: cycles already spent waiting on the current access.
  int          m_wait;
  bit          m_bus_err, m_mis, m_rw, m_m2r;
  logic [31:0] m_rd, m_alu;
  logic [4:0]  m_wreg;
  bit          e_req, e_stall, e_pc, e_tmo, e_acc, e_mis;

  task automatic model_reset();
    m_wait = 0; m_bus_err = 0; m_mis = 0; m_rw = 0; m_m2r = 0;
    m_rd = 32'h0; m_alu = 32'h0; m_wreg = 5'h0;
  endtask

  task automatic model_comb();
    e_mis   = (rd_i || wr_i) && (alu_i % 4 != 0);
    e_acc   = (rd_i || wr_i) && !e_mis;
    e_tmo   = (m_wait == TO - 1);
    e_req   = e_acc;
    e_stall = e_acc && !dmem_ack && !e_tmo;
    e_pc    = br_i && zero_i && !e_stall;
  endtask

  task automatic model_clock();
    bit done, abort;
    done  = e_acc && dmem_ack;
    abort = e_acc && !dmem_ack && e_tmo;
    if (e_mis || e_stall || abort) begin
      m_rw = 0; m_m2r = 0;
    end else begin
      m_rw = rw_i; m_m2r = m2r_i; m_alu = alu_i; m_wreg = wreg_i;
      if (done && rd_i && !wr_i) m_rd = dmem_rdata;
    end
    m_mis = e_mis;
    if (abort) m_bus_err = 1;
    m_wait = e_stall ? m_wait + 1 : 0;
  endtask

  task automatic set_instr(input bit rw, input bit m2r, input bit br, input bit rd,
                           input bit wr, input bit z, input logic [31:0] tgt,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg);
    rw_i = rw; m2r_i = m2r; br_i = br; rd_i = rd; wr_i = wr; zero_i = z;
    tgt_i = tgt; alu_i = addr; wd_i = wd; wreg_i = wreg;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rw_o, m2r_o, rd_o, alu_o, wreg_o, misaligned_err, bus_err} !== 72'h0) begin
      n_errors++; $display("FAIL reset_mem_wb got rw=%0b m2r=%0b rd=%h alu=%h wreg=%0d mis=%0b bus=%0b exp all 0",
                           rw_o, m2r_o, rd_o, alu_o, wreg_o, misaligned_err, bus_err);
    end
    n_checks++;
    if ({dmem_req, mem_stall, pc_src} !== 3'b000) begin
      n_errors++; $display("FAIL reset_comb got req/stall/pc=%b exp 000", {dmem_req, mem_stall, pc_src});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait_load();
    set_instr(1, 1, 0, 1, 0, 0, 32'h0, 32'h100, 32'h0, 5'd5);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, mem_stall} !== 3'b100) begin
      n_errors++; $display("FAIL zw_comb got req/we/stall=%b exp 100", {dmem_req, dmem_we, mem_stall});
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_o !== 32'hDEADBEEF || rw_o !== 1'b1 || m2r_o !== 1'b1 || wreg_o !== 5'd5) begin
      n_errors++; $display("FAIL zw_wb got rd=%h rw=%0b m2r=%0b wreg=%0d exp deadbeef 1 1 5", rd_o, rw_o, m2r_o, wreg_o);
    end
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
    dmem_ack = 1'b0;
  endtask

  task automatic test_wait_store();
    int n_req, n_stall;
    n_req = 0; n_stall = 0;
    set_instr(0, 0, 0, 0, 1, 0, 32'h0, 32'h200, 32'h12345678, 5'd2);
    for (int c = 1; c <= 4; c++) begin
      dmem_ack = (c == 4);
      #1;
      if (dmem_req && dmem_we && dmem_addr == 32'h200 && dmem_wdata == 32'h12345678) n_req++;
      if (mem_stall) n_stall++;
      @(posedge clk); #1;
      n_checks++;
      if (rw_o !== 1'b0) begin
        n_errors++; $display("FAIL ws_regwrite cycle %0d got %0b exp 0", c, rw_o);
      end
    end
    n_checks++;
    if (n_req != 4 || n_stall != 3) begin
      n_errors++; $display("FAIL ws_counts got req=%0d stall=%0d exp 4 3", n_req, n_stall);
    end
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_errors++; $display("FAIL ws_bus_err got %0b exp 0", bus_err);
    end
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
    dmem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int n_stall;
    bit ended;
    n_stall = 0; ended = 0;
    set_instr(1, 1, 0, 1, 0, 0, 32'h0, 32'h300, 32'h0, 5'd6);
    dmem_ack = 1'b0;
    for (int c = 0; c < 24 && !ended; c++) begin
      bit s;
      #1;
      s = mem_stall;
      if (s) n_stall++;
      @(posedge clk); #1;
      n_checks++;
      if (rw_o !== 1'b0 || rd_o !== 32'hDEADBEEF) begin
        n_errors++; $display("FAIL to_bubble cycle %0d got rw=%0b rd=%h exp 0 deadbeef", c, rw_o, rd_o);
      end
      if (!s) ended = 1;
    end
    n_checks++;
    if (!ended || n_stall != TO - 1 || bus_err !== 1'b1) begin
      n_errors++; $display("FAIL to_stall got ended=%0b stalls=%0d bus=%0b exp 1 %0d 1", ended, n_stall, bus_err, TO - 1);
    end
    set_instr(1, 0, 0, 0, 0, 0, 32'h0, 32'h55, 32'h0, 5'd7);
    #1;
    n_checks++;
    if (mem_stall !== 1'b0) begin
      n_errors++; $display("FAIL to_next_stall got %0b exp 0", mem_stall);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rw_o !== 1'b1 || m2r_o !== 1'b0 || alu_o !== 32'h55 || wreg_o !== 5'd7 || bus_err !== 1'b1) begin
      n_errors++; $display("FAIL to_next_wb got rw=%0b m2r=%0b alu=%h wreg=%0d bus=%0b exp 1 0 55 7 1",
                           rw_o, m2r_o, alu_o, wreg_o, bus_err);
    end
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
  endtask

  task automatic test_ack_on_timeout();
    int n_stall;
    do_reset();
    n_stall = 0;
    set_instr(1, 1, 0, 1, 0, 0, 32'h0, 32'h400, 32'h0, 5'd9);
    for (int c = 1; c <= TO; c++) begin
      dmem_ack = (c == TO);
      dmem_rdata = (c == TO) ? 32'hCAFEF00D : 32'h0BAD0BAD;
      #1;
      if (mem_stall) n_stall++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_stall != TO - 1 || bus_err !== 1'b0) begin
      n_errors++; $display("FAIL aot_stall got stalls=%0d bus=%0b exp %0d 0", n_stall, bus_err, TO - 1);
    end
    n_checks++;
    if (rd_o !== 32'hCAFEF00D || rw_o !== 1'b1 || m2r_o !== 1'b1 || wreg_o !== 5'd9) begin
      n_errors++; $display("FAIL aot_wb got rd=%h rw=%0b m2r=%0b wreg=%0d exp cafef00d 1 1 9", rd_o, rw_o, m2r_o, wreg_o);
    end
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
    dmem_ack = 1'b0;
  endtask

  task automatic test_misaligned_branch();
    set_instr(1, 1, 0, 1, 0, 0, 32'h0, 32'h102, 32'h0, 5'd8);
    #1;
    n_checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      n_errors++; $display("FAIL mis_comb got req/stall=%b exp 00", {dmem_req, mem_stall});
    end
    @(posedge clk); #1;
    n_checks++;
    if (misaligned_err !== 1'b1 || rw_o !== 1'b0) begin
      n_errors++; $display("FAIL mis_pulse got mis=%0b rw=%0b exp 1 0", misaligned_err, rw_o);
    end
    set_instr(0, 0, 1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 5'h0);
    #1;
    n_checks++;
    if (pc_src !== 1'b1 || branch_target !== 32'h40) begin
      n_errors++; $display("FAIL beq_taken got pc_src=%0b tgt=%h exp 1 40", pc_src, branch_target);
    end
    @(posedge clk); #1;
    n_checks++;
    if (misaligned_err !== 1'b0) begin
      n_errors++; $display("FAIL mis_one_cycle got %0b exp 0", misaligned_err);
    end
    zero_i = 1'b0;
    #1;
    n_checks++;
    if (pc_src !== 1'b0) begin
      n_errors++; $display("FAIL beq_not_taken got %0b exp 0", pc_src);
    end
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
  endtask

  task automatic test_reset_mid_wait();
    int n_stall;
    bit ended;
    set_instr(1, 0, 0, 0, 0, 0, 32'h0, 32'hAA, 32'h0, 5'd3);
    @(posedge clk); #1;
    set_instr(1, 1, 0, 1, 0, 0, 32'h0, 32'h500, 32'h0, 5'd4);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, mem_stall, rw_o, m2r_o, rd_o, alu_o, wreg_o} !== 73'h0) begin
      n_errors++; $display("FAIL rmw_async got req=%0b stall=%0b rw=%0b m2r=%0b rd=%h alu=%h wreg=%0d exp all 0",
                           dmem_req, mem_stall, rw_o, m2r_o, rd_o, alu_o, wreg_o);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_stall = 0; ended = 0;
    for (int c = 0; c < 24 && !ended; c++) begin
      bit s;
      #1;
      s = mem_stall;
      if (s) n_stall++;
      @(posedge clk); #1;
      if (!s) ended = 1;
    end
    n_checks++;
    if (!ended || n_stall != TO - 1) begin
      n_errors++; $display("FAIL rmw_idle got ended=%0b stalls=%0d exp 1 %0d", ended, n_stall, TO - 1);
    end
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 80; n++) begin
      int kind, lat;
      bit ended;
      logic [31:0] addr;
      kind = $urandom_range(0, 4);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      set_instr($urandom_range(0, 1), $urandom_range(0, 1), kind == 3, kind == 1 || kind == 4,
                kind == 2 || kind == 4, $urandom_range(0, 1), $urandom, addr, $urandom, 5'($urandom));
      lat = $urandom_range(0, TO + 1);
      ended = 0;
      for (int k = 0; k < TO + 4 && !ended; k++) begin
        bit stall_now;
        dmem_rdata = $urandom;
        dmem_ack = (rd_i || wr_i) ? (k == lat) : 1'($urandom_range(0, 1));
        #1;
        model_comb();
        stall_now = e_stall;
        n_checks++;
        if ({dmem_req, dmem_we, mem_stall, pc_src} !== {e_req, wr_i, e_stall, e_pc} ||
            dmem_addr !== alu_i || dmem_wdata !== wd_i || branch_target !== tgt_i) begin
          n_errors++; $display("FAIL rnd_comb instr %0d cyc %0d got req/we/stall/pc=%b exp %b",
                               n, k, {dmem_req, dmem_we, mem_stall, pc_src}, {e_req, wr_i, e_stall, e_pc});
        end
        @(posedge clk);
        model_clock();
        #1;
        n_checks++;
        if ({rw_o, m2r_o, misaligned_err, bus_err} !== {m_rw, m_m2r, m_mis, m_bus_err} ||
            rd_o !== m_rd || alu_o !== m_alu || wreg_o !== m_wreg) begin
          n_errors++; $display("FAIL rnd_wb instr %0d cyc %0d got rw/m2r/mis/bus=%b rd=%h alu=%h wreg=%0d exp %b %h %h %0d",
                               n, k, {rw_o, m2r_o, misaligned_err, bus_err}, rd_o, alu_o, wreg_o,
                               {m_rw, m_m2r, m_mis, m_bus_err}, m_rd, m_alu, m_wreg);
        end
        if (!stall_now) ended = 1;
      end
      n_checks++;
      if (!ended) begin
        n_errors++; $display("FAIL rnd_bound instr %0d got still stalled exp done within %0d cycles", n, TO + 4);
      end
    end
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'h0);
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_timeout();
    test_ack_on_timeout();
    test_misaligned_branch();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM pipeline register outputs and runs the load/store handshake with a variable-latency data memory.
- Generates the branch redirect and the pipeline stall, and holds the MEM/WB pipeline register that feeds write-back.

Parameters:
DATA_W, 32, data/address width
REG_W, 5, register-index width
TIMEOUT, 16, max cycles a request may wait for dmem_ack before abort (>=2)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
ctrl_regWrite_ex_mem  in  1  register write enable from EX/MEM
ctrl_memToReg_ex_mem  in  1  write-back source select (1 = memory data)
ctrl_branch_ex_mem  in  1  instruction is a branch
ctrl_memRead_ex_mem  in  1  instruction is a load
ctrl_memWrite_ex_mem  in  1  instruction is a store
zero_ex_mem  in  1  ALU zero flag
branch_or_not_address_ex_mem  in  DATA_W  branch target
alu_result_ex_mem  in  DATA_W  ALU result / memory address
read_data_2_ex_mem  in  DATA_W  store data
write_register_ex_mem  in  REG_W  destination register
dmem_req  out  1  memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  DATA_W  memory address
dmem_wdata  out  DATA_W  write data
dmem_ack  in  1  request complete this cycle
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
pc_src  out  1  take branch
branch_target  out  DATA_W  redirect PC
mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
ctrl_regWrite_mem_wb  out  1  MEM/WB register write enable
ctrl_memToReg_mem_wb  out  1  MEM/WB write-back source select
read_data_mem_wb  out  DATA_W  MEM/WB load data
alu_result_mem_wb  out  DATA_W  MEM/WB ALU result
write_register_mem_wb  out  REG_W  MEM/WB destination register
misaligned_err  out  1  one-cycle pulse: misaligned access dropped
bus_err  out  1  sticky: access timed out

Behaviour:
Reset and clocking
- One clock; reset is asynchronous and active-high.
- On reset, all MEM/WB outputs, misaligned_err and bus_err are 0, the FSM is in IDLE and the wait counter is 0.
- Reset mid-WAIT aborts immediately. dmem_req drops combinationally, and no MEM/WB update occurs.

Access qualification
- mis = (memRead|memWrite) & (alu_result_ex_mem[1:0] != 0).
- acc = (memRead|memWrite) & ~mis.
- memRead and memWrite both set: treat as a store (dmem_we = 1).

Memory interface (combinational)
- dmem_req = acc in IDLE or WAIT; 0 otherwise.
- dmem_addr = alu_result_ex_mem.
- dmem_wdata = read_data_2_ex_mem.
- dmem_we = memWrite.
- dmem_ack is ignored when dmem_req = 0.

Stall (combinational)
- mem_stall = dmem_req & ~dmem_ack & ~timeout_now.
- timeout_now = (state == WAIT) & (cnt == TIMEOUT-1).
- Upstream EX/MEM inputs are held stable while mem_stall = 1.

FSM
- IDLE:
  - acc & dmem_ack: complete (zero-wait); stay in IDLE.
  - acc & ~dmem_ack: go to WAIT, cnt <= 1.
- WAIT:
  - dmem_ack: complete, go to IDLE, cnt <= 0.
  - Else if timeout_now: abort, bus_err <= 1 (sticky until reset), go to IDLE.
  - Else cnt <= cnt+1.
- dmem_ack and timeout_now in the same cycle: ack wins, access completes normally.

MEM/WB register (updates every rising edge)
- Completing access or non-memory instruction:
  - MEM/WB control, alu_result_mem_wb and write_register_mem_wb <= EX/MEM values.
  - read_data_mem_wb <= dmem_rdata on load completion; holds its old value otherwise.
- Stall cycle (mem_stall = 1), abort, or mis:
  - Bubble: ctrl_regWrite_mem_wb <= 0 and ctrl_memToReg_mem_wb <= 0.
  - Data fields hold their values.
- misaligned_err <= mis; a one-cycle pulse per offending instruction. No request is issued and there is no stall.

Branch
- pc_src = ctrl_branch_ex_mem & zero_ex_mem & ~mem_stall (combinational).
- branch_target = branch_or_not_address_ex_mem.

Latency
- Load data appears at MEM/WB one edge after the dmem_ack cycle.
- Stall length equals the memory wait cycles, capped at TIMEOUT-1.

Test Plan:
- Zero-wait load: memRead=1, addr=0x100, dmem_ack=1 with rdata=0xDEADBEEF in the same cycle, write_register=5 -> no stall; next edge read_data_mem_wb=0xDEADBEEF, regWrite_mem_wb=1, memToReg_mem_wb=1, write_register_mem_wb=5.
- 3-wait store: memWrite=1, addr=0x200, wdata=0x12345678, ack on the 4th cycle -> dmem_req high 4 cycles with dmem_we=1, mem_stall high 3 cycles, MEM/WB regWrite=0 throughout, no bus_err.
- Timeout: load, dmem_ack never asserted, TIMEOUT=16 -> mem_stall high 15 cycles, then drops; bus_err=1 and stays 1; MEM/WB bubble; next instruction proceeds normally.
- Ack on the timeout cycle: ack arrives in cycle 16 of a load -> completes, bus_err stays 0, data is captured.
- Misaligned load: addr=0x102 -> dmem_req=0, misaligned_err pulses 1 cycle, regWrite_mem_wb=0; beq with zero=1, target=0x40 -> pc_src=1, branch_target=0x40.
- Reset mid-WAIT: assert reset in cycle 2 of a pending load -> dmem_req, mem_stall and all MEM/WB outputs go to 0 immediately; after release, FSM is in IDLE.
